execute_pipe: RTL and testbench

Pipelined execute stage for the LEGv8 datapath: the successor of the single-cycle execute block, generalised to width `N`. It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline register. It adds operand forwarding, a valid/ready handshake with stall and flush, and an optional iterative multiplier. It computes the branch target, the ALU result, store data and the zero flag, and registers them for the memory stage.

---
 rtl/execute_pipe_if.sv | 38 +++
 rtl/execute_pipe.sv | 173 +++++++++++++++++
 tb/tb_execute_pipe.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_pipe_if.sv
// execute_pipe_if: ID/EX-to-EX/MEM bus of the LEGv8 execute stage.
// The master drives the ID/EX operands, the hazard-unit controls and the
// writeback forwarding value. The slave (the execute stage) drives the
// ready handshake and the EX/MEM register contents.
interface execute_pipe_if #(
  parameter int N = 64
);
  logic         valid_E;
  logic         ready_E;
  logic         flush_E;
  logic         stall_M;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [1:0]   ForwardA;
  logic [1:0]   ForwardB;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic [N-1:0] wbData_W;
  logic [N-1:0] PCBranch_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic         zero_M;
  logic         valid_M;

  modport master (
    output valid_E, flush_E, stall_M, AluSrc, AluControl, ForwardA, ForwardB,
           PC_E, signImm_E, readData1_E, readData2_E, wbData_W,
    input  ready_E, PCBranch_M, aluResult_M, writeData_M, zero_M, valid_M
  );

  modport slave (
    input  valid_E, flush_E, stall_M, AluSrc, AluControl, ForwardA, ForwardB,
           PC_E, signImm_E, readData1_E, readData2_E, wbData_W,
    output ready_E, PCBranch_M, aluResult_M, writeData_M, zero_M, valid_M
  );
endinterface

// File: rtl/execute_pipe.sv
// execute_pipe: pipelined LEGv8 execute stage owning the EX/MEM register.
// Operand forwarding, ALU, branch target, valid/ready handshake with
// stall (freeze EX/MEM) and flush (kill in-flight work).
// Define EXECUTE_MUL_EN to build the iterative shift-add multiplier
// (AluControl 1000, N-cycle latency, MUL/HOLD states); without it 1000
// is an unlisted code that yields 0.
module execute_pipe #(
  parameter int N = 64
) (
  input logic           clk,
  input logic           reset,
  execute_pipe_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;

  state_t       state_q;
  logic [N-1:0] pcBranch_q;
  logic [N-1:0] aluResult_q;
  logic [N-1:0] writeData_q;
  logic         zero_q;
  logic         valid_q;

  logic [N-1:0] fwdA_d;
  logic [N-1:0] fwdB_d;
  logic [N-1:0] aluB_d;
  logic [N-1:0] aluResult_d;
  logic [N-1:0] pcBranch_d;

  // Forwarding muxes pick the freshest copy of each source operand
  always_comb begin
    case (bus.ForwardA)
      2'b10:   fwdA_d = aluResult_q;
      2'b01:   fwdA_d = bus.wbData_W;
      default: fwdA_d = bus.readData1_E;
    endcase
    case (bus.ForwardB)
      2'b10:   fwdB_d = aluResult_q;
      2'b01:   fwdB_d = bus.wbData_W;
      default: fwdB_d = bus.readData2_E;
    endcase
    aluB_d = bus.AluSrc ? bus.signImm_E : fwdB_d;
  end

  // Single-cycle ALU and word-aligned branch target
  always_comb begin
    case (bus.AluControl)
      4'b0000: aluResult_d = fwdA_d & aluB_d;
      4'b0001: aluResult_d = fwdA_d | aluB_d;
      4'b0010: aluResult_d = fwdA_d + aluB_d;
      4'b0110: aluResult_d = fwdA_d + ~aluB_d + {{(N-1){1'b0}}, 1'b1};
      4'b0111: aluResult_d = aluB_d;
      4'b1100: aluResult_d = ~(fwdA_d | aluB_d);
      default: aluResult_d = '0;
    endcase
    pcBranch_d = bus.PC_E + {bus.signImm_E[N-3:0], 2'b00};
  end

`ifdef EXECUTE_MUL_EN
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  mcand_q;
  logic [N-1:0]  mplier_q;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  mulWd_q;
  logic [N-1:0]  mulPc_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  accNext_d;
  logic          isMul_d;

  // One shift-add step: accumulate the shifted multiplicand on a set multiplier LSB
  always_comb begin
    isMul_d   = (bus.AluControl == 4'b1000);
    accNext_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end
`endif

  // EX/MEM register and stage FSM: flush beats stall, stall freezes EX/MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pcBranch_q  <= '0;
      aluResult_q <= '0;
      writeData_q <= '0;
      zero_q      <= 1'b0;
      valid_q     <= 1'b0;
`ifdef EXECUTE_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mulWd_q     <= '0;
      mulPc_q     <= '0;
      cnt_q       <= '0;
`endif
    end else if (bus.flush_E) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.stall_M) begin
            if (bus.valid_E) begin
`ifdef EXECUTE_MUL_EN
              if (isMul_d) begin
                mcand_q  <= fwdA_d;
                mplier_q <= aluB_d;
                acc_q    <= '0;
                cnt_q    <= '0;
                mulWd_q  <= fwdB_d;
                mulPc_q  <= pcBranch_d;
                valid_q  <= 1'b0;
                state_q  <= MUL;
              end else begin
`endif
                aluResult_q <= aluResult_d;
                zero_q      <= (aluResult_d == '0);
                writeData_q <= fwdB_d;
                pcBranch_q  <= pcBranch_d;
                valid_q     <= 1'b1;
`ifdef EXECUTE_MUL_EN
              end
`endif
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
`ifdef EXECUTE_MUL_EN
        MUL: begin
          acc_q    <= accNext_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if (!bus.stall_M) begin
              aluResult_q <= accNext_d;
              zero_q      <= (accNext_d == '0);
              writeData_q <= mulWd_q;
              pcBranch_q  <= mulPc_q;
              valid_q     <= 1'b1;
              state_q     <= IDLE;
            end else begin
              state_q <= HOLD;
            end
          end else if (!bus.stall_M) begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall_M) begin
            aluResult_q <= acc_q;
            zero_q      <= (acc_q == '0);
            writeData_q <= mulWd_q;
            pcBranch_q  <= mulPc_q;
            valid_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_E     = (state_q == IDLE) && !bus.stall_M;
  assign bus.PCBranch_M  = pcBranch_q;
  assign bus.aluResult_M = aluResult_q;
  assign bus.writeData_M = writeData_q;
  assign bus.zero_M      = zero_q;
  assign bus.valid_M     = valid_q;

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed self-checking bench for execute_pipe.
// A behavioural model (plain arithmetic plus a countdown for the multiply)
// predicts EX/MEM every cycle; literal expectations pin the model.
// Covers the EXECUTE_MUL_EN build and the default build.
`timescale 1ns/1ps
module tb_execute_pipe;
  localparam int N = 64;
`ifdef EXECUTE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passCount = 0;
  int   checkCount = 0;

  execute_pipe_if #(.N(N)) bus ();

  execute_pipe #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected EX/MEM contents and multiply bookkeeping
  logic [N-1:0] eAlu = '0, eWd = '0, ePc = '0;
  logic         eZero = 1'b0, eValid = 1'b0;
  int           mulLeft = 0;
  logic [N-1:0] mRes = '0, mWd = '0, mPc = '0;

  function automatic logic [N-1:0] pickOperand(input logic [1:0] sel, input logic [N-1:0] rf,
                                               input logic [N-1:0] mem, input logic [N-1:0] wb);
    if (sel == 2'b10) return mem;
    if (sel == 2'b01) return wb;
    return rf;
  endfunction

  function automatic logic [N-1:0] aluModel(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      4'b1000: return MulEn ? a * b : '0;
      default: return '0;
    endcase
  endfunction

  // Behavioural model: results appear one edge after accept, products N edges after
  always @(posedge clk or negedge reset) begin : modelBlock
    logic [N-1:0] a, b, fb, r;
    if (!reset) begin
      eAlu = '0; eWd = '0; ePc = '0; eZero = 1'b0; eValid = 1'b0; mulLeft = 0;
    end else if (bus.flush_E) begin
      mulLeft = 0;
      eValid  = 1'b0;
    end else if (mulLeft > 1) begin
      mulLeft = mulLeft - 1;
      if (!bus.stall_M) eValid = 1'b0;
    end else if (mulLeft == 1) begin
      if (!bus.stall_M) begin
        eAlu = mRes; eZero = (mRes == '0); eWd = mWd; ePc = mPc; eValid = 1'b1; mulLeft = 0;
      end
    end else if (!bus.stall_M) begin
      if (bus.valid_E) begin
        a  = pickOperand(bus.ForwardA, bus.readData1_E, eAlu, bus.wbData_W);
        fb = pickOperand(bus.ForwardB, bus.readData2_E, eAlu, bus.wbData_W);
        b  = bus.AluSrc ? bus.signImm_E : fb;
        r  = aluModel(bus.AluControl, a, b);
        if (MulEn && bus.AluControl == 4'b1000) begin
          mRes = r; mWd = fb; mPc = bus.PC_E + (bus.signImm_E << 2);
          mulLeft = N; eValid = 1'b0;
        end else begin
          eAlu = r; eZero = (r == '0); eWd = fb; ePc = bus.PC_E + (bus.signImm_E << 2);
          eValid = 1'b1;
        end
      end else begin
        eValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic compareCycle();
    checkOutput("aluResult_M", bus.aluResult_M, eAlu);
    checkOutput("writeData_M", bus.writeData_M, eWd);
    checkOutput("PCBranch_M", bus.PCBranch_M, ePc);
    checkOutput("zero_M", N'(bus.zero_M), N'(eZero));
    checkOutput("valid_M", N'(bus.valid_M), N'(eValid));
    checkOutput("ready_E", N'(bus.ready_E), N'((mulLeft == 0) && !bus.stall_M));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic src,
                               input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                               input logic [N-1:0] imm);
    bus.valid_E     = v;
    bus.AluControl  = op;
    bus.AluSrc      = src;
    bus.readData1_E = rd1;
    bus.readData2_E = rd2;
    bus.signImm_E   = imm;
    tick();
  endtask

  initial begin
    int cnt;
    bus.valid_E = 1'b0; bus.flush_E = 1'b0; bus.stall_M = 1'b0; bus.AluSrc = 1'b0;
    bus.AluControl = 4'b0000; bus.ForwardA = 2'b00; bus.ForwardB = 2'b00;
    bus.PC_E = '0; bus.signImm_E = '0; bus.readData1_E = '0; bus.readData2_E = '0;
    bus.wbData_W = '0;

    fork
      forever begin
        @(negedge clk);
        compareCycle();
      end
    join_none

    // Reset held for three cycles
    repeat (3) tick();
    checkOutput("rst aluResult", bus.aluResult_M, '0);
    checkOutput("rst PCBranch", bus.PCBranch_M, '0);
    checkOutput("rst valid", N'(bus.valid_M), '0);
    checkOutput("rst zero", N'(bus.zero_M), '0);
    reset = 1'b1;
    checkOutput("ready after reset", N'(bus.ready_E), N'(1));

    // ADD 5 + 7
    applyStimulus(1'b1, 4'b0010, 1'b0, 5, 7, 0);
    checkOutput("add result", bus.aluResult_M, 12);
    checkOutput("add zero", N'(bus.zero_M), '0);
    checkOutput("add valid", N'(bus.valid_M), N'(1));

    // Forward previous result into A, SUB immediate 12
    bus.ForwardA = 2'b10;
    applyStimulus(1'b1, 4'b0110, 1'b1, 99, 0, 12);
    checkOutput("fwdA sub result", bus.aluResult_M, 0);
    checkOutput("fwdA sub zero", N'(bus.zero_M), N'(1));

    // Forward writeback into B; store data is fwdB, not the immediate
    bus.ForwardA = 2'b00; bus.ForwardB = 2'b01; bus.wbData_W = 'h55;
    applyStimulus(1'b1, 4'b0010, 1'b1, 1, 0, 2);
    checkOutput("fwdB writeData", bus.writeData_M, 'h55);
    checkOutput("fwdB add imm", bus.aluResult_M, 3);
    bus.ForwardB = 2'b00; bus.wbData_W = '0;

    // Branch targets
    bus.PC_E = 'h100;
    applyStimulus(1'b1, 4'b0010, 1'b1, 0, 0, N'(-4));
    checkOutput("branch -4", bus.PCBranch_M, 'hF0);
    applyStimulus(1'b1, 4'b0010, 1'b1, 0, 0, 3);
    checkOutput("branch +3", bus.PCBranch_M, 'h10C);

    // Logic op sweep
    applyStimulus(1'b1, 4'b0000, 1'b0, 'hF0, 'h3C, 0);
    checkOutput("and", bus.aluResult_M, 'h30);
    applyStimulus(1'b1, 4'b0001, 1'b0, 'hF0, 'h3C, 0);
    checkOutput("or", bus.aluResult_M, 'hFC);
    applyStimulus(1'b1, 4'b0111, 1'b0, 'hF0, 'h3C, 0);
    checkOutput("passB", bus.aluResult_M, 'h3C);
    applyStimulus(1'b1, 4'b0101, 1'b0, 'hF0, 'h3C, 0);
    checkOutput("unlisted zero", N'(bus.zero_M), N'(1));
    applyStimulus(1'b1, 4'b1100, 1'b0, 'hF0, 'h0F, 0);
    checkOutput("nor", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FF00);

    // Stall four cycles: EX/MEM frozen, ready low, then a bubble
    bus.stall_M = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0010, 1'b0, 1, 1, 0);
      checkOutput("stall frozen result", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FF00);
      checkOutput("stall frozen valid", N'(bus.valid_M), N'(1));
      checkOutput("stall ready low", N'(bus.ready_E), '0);
    end
    bus.stall_M = 1'b0;
    applyStimulus(1'b0, 4'b0010, 1'b0, 1, 1, 0);
    checkOutput("bubble valid", N'(bus.valid_M), '0);

    // Flush beats stall; flush discards a same-cycle transfer
    applyStimulus(1'b1, 4'b0010, 1'b0, 2, 2, 0);
    bus.stall_M = 1'b1; bus.flush_E = 1'b1;
    applyStimulus(1'b0, 4'b0010, 1'b0, 2, 2, 0);
    checkOutput("flush+stall valid", N'(bus.valid_M), '0);
    checkOutput("flush+stall data hold", bus.aluResult_M, 4);
    bus.stall_M = 1'b0;
    applyStimulus(1'b1, 4'b0010, 1'b0, 3, 3, 0);
    checkOutput("flush discards transfer", bus.aluResult_M, 4);
    bus.flush_E = 1'b0;

`ifdef EXECUTE_MUL_EN
    // Full-width multiply, exactly N edges after accept
    bus.PC_E = 'h200;
    applyStimulus(1'b1, 4'b1000, 1'b0, '1, 3, 0);
    bus.valid_E = 1'b0;
    checkOutput("mul ready low", N'(bus.ready_E), '0);
    cnt = 1;
    tick();
    while (bus.valid_M !== 1'b1 && cnt < 4 * N) begin
      tick();
      cnt++;
    end
    checkOutput("mul latency", N'(cnt), N'(N));
    checkOutput("mul result", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("mul writeData", bus.writeData_M, 3);
    checkOutput("mul PCBranch", bus.PCBranch_M, 'h200);

    // Stall on the final step parks the product until release
    applyStimulus(1'b1, 4'b1000, 1'b0, 6, 7, 0);
    bus.valid_E = 1'b0;
    repeat (N - 1) tick();
    bus.stall_M = 1'b1;
    repeat (3) tick();
    checkOutput("hold valid low", N'(bus.valid_M), '0);
    bus.stall_M = 1'b0;
    checkOutput("hold ready low", N'(bus.ready_E), '0);
    tick();
    checkOutput("hold release valid", N'(bus.valid_M), N'(1));
    checkOutput("hold release result", bus.aluResult_M, 42);

    // Flush at multiply cycle 10
    applyStimulus(1'b1, 4'b1000, 1'b0, 5, 9, 0);
    bus.valid_E = 1'b0;
    repeat (9) tick();
    bus.flush_E = 1'b1;
    tick();
    bus.flush_E = 1'b0;
    checkOutput("mul flush valid", N'(bus.valid_M), '0);
    checkOutput("mul flush ready", N'(bus.ready_E), N'(1));
    repeat (4) tick();
    applyStimulus(1'b1, 4'b0010, 1'b0, 1, 1, 0);
    checkOutput("add after flush", bus.aluResult_M, 2);

    // Reset in the middle of a multiply
    applyStimulus(1'b1, 4'b1000, 1'b0, 5, 9, 0);
    bus.valid_E = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #2;
    checkOutput("mul reset valid", N'(bus.valid_M), '0);
    checkOutput("mul reset result", bus.aluResult_M, '0);
    tick();
    reset = 1'b1;
    checkOutput("mul reset ready", N'(bus.ready_E), N'(1));
    repeat (N + 2) tick();
    applyStimulus(1'b1, 4'b0010, 1'b0, 1, 1, 0);
    checkOutput("add after reset", bus.aluResult_M, 2);
`else
    // Without the multiplier 1000 is an unlisted single-cycle code
    applyStimulus(1'b1, 4'b1000, 1'b0, 5, 3, 0);
    checkOutput("code1000 result", bus.aluResult_M, 0);
    checkOutput("code1000 zero", N'(bus.zero_M), N'(1));
    checkOutput("code1000 valid", N'(bus.valid_M), N'(1));
    applyStimulus(1'b1, 4'b0010, 1'b0, 1, 1, 0);
    checkOutput("add after 1000", bus.aluResult_M, 2);
`endif

    applyStimulus(1'b0, 4'b0000, 1'b0, 0, 0, 0);
    tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
